// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic DEPTH-entry pipeline stage buffer; define PIPE_STAGE_BUF_ZERO_ON_FLUSH_EN to also clear storage on flush
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << PW;
  logic [DATA_W+CTRL_W-1:0] mem [SLOTS];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic push, pop;
  assign in_ready = count != CNT_W'(DEPTH);
  assign out_valid = count != '0;
  assign push = in_valid & in_ready & ~flush;
  assign pop = out_valid & out_ready & ~flush;
  assign wr_nxt = wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
  assign rd_nxt = rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
  assign out_data = mem[rd_ptr][DATA_W+CTRL_W-1:CTRL_W];
  assign out_ctrl = out_valid ? mem[rd_ptr][CTRL_W-1:0] : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < SLOTS; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
`ifdef PIPE_STAGE_BUF_ZERO_ON_FLUSH_EN
      for (int i = 0; i < SLOTS; i++) mem[i] <= '0;
`endif
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_data, in_ctrl};
        wr_ptr <= wr_nxt;
      end
      if (pop) rd_ptr <= rd_nxt;
      if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: three instances (DEPTH 2, 3, 1) driven in parallel and checked against a sequence-log model
module tb_pipe_stage_buf;
  logic clk = 1'b0;
  logic reset, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic [7:0] in_ctrl;
  logic in_rdy [3];
  logic out_vld [3];
  logic [31:0] out_dat [3];
  logic [7:0] out_ctl [3];
  logic [3:0] cnt [3];
  int total = 0, bad = 0;
  // every accepted entry is logged by sequence number; the held entries are mlog[mrd..mwr-1]
  logic [39:0] mlog [3][4096];
  int mrd [3];
  int mwr [3];

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .DEPTH(2), .CNT_W(4)) u0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_rdy[0]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_vld[0]), .out_ready(out_ready),
    .out_data(out_dat[0]), .out_ctrl(out_ctl[0]), .count(cnt[0]));
  pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .DEPTH(3), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_rdy[1]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_vld[1]), .out_ready(out_ready),
    .out_data(out_dat[1]), .out_ctrl(out_ctl[1]), .count(cnt[1]));
  pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .DEPTH(1), .CNT_W(4)) u2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_rdy[2]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_vld[2]), .out_ready(out_ready),
    .out_data(out_dat[2]), .out_ctrl(out_ctl[2]), .count(cnt[2]));

  function automatic int dep(int k);
    return k == 0 ? 2 : k == 1 ? 3 : 1;
  endfunction

  function automatic int msz(int k);
    return mwr[k] - mrd[k];
  endfunction

  task automatic tick();
    for (int k = 0; k < 3; k++) begin
      bit pu, po;
      pu = in_valid && msz(k) != dep(k) && !flush;
      po = out_ready && msz(k) != 0 && !flush;
      if (flush) mrd[k] = mwr[k];
      else begin
        if (po) mrd[k]++;
        if (pu) begin
          mlog[k][mwr[k]] = {in_data, in_ctrl};
          mwr[k]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    in_valid = 1'b0;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    in_ctrl = '0;
    for (int k = 0; k < 3; k++) begin
      mrd[k] = 0;
      mwr[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total += 5;
      if (cnt[k] !== 4'd0) begin bad++; $display("FAIL reset_count[%0d] got=%0d exp=0", k, cnt[k]); end
      if (in_rdy[k] !== 1'b1) begin bad++; $display("FAIL reset_in_ready[%0d] got=%b exp=1", k, in_rdy[k]); end
      if (out_vld[k] !== 1'b0) begin bad++; $display("FAIL reset_out_valid[%0d] got=%b exp=0", k, out_vld[k]); end
      if (out_dat[k] !== 32'h0) begin bad++; $display("FAIL reset_out_data[%0d] got=%h exp=0", k, out_dat[k]); end
      if (out_ctl[k] !== 8'h0) begin bad++; $display("FAIL reset_out_ctrl[%0d] got=%h exp=0", k, out_ctl[k]); end
    end
    in_valid = 1'b1;
    in_data = 32'hdead_beef;
    in_ctrl = 8'h5a;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (out_vld[k] !== 1'b1) begin bad++; $display("FAIL held_before_reset[%0d] got=%b exp=1", k, out_vld[k]); end
    end
    #1 reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      total += 4;
      if (out_vld[k] !== 1'b0) begin bad++; $display("FAIL async_reset_valid[%0d] got=%b exp=0", k, out_vld[k]); end
      if (cnt[k] !== 4'd0) begin bad++; $display("FAIL async_reset_count[%0d] got=%0d exp=0", k, cnt[k]); end
      if (out_ctl[k] !== 8'h0) begin bad++; $display("FAIL async_reset_ctrl[%0d] got=%h exp=0", k, out_ctl[k]); end
      if (out_dat[k] !== 32'h0) begin bad++; $display("FAIL async_reset_data[%0d] got=%h exp=0", k, out_dat[k]); end
      mrd[k] = mwr[k];
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    in_valid = 1'b1;
    out_ready = 1'b0;
    in_data = 32'hA5A5_0001;
    in_ctrl = 8'h03;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total += 4;
      if (out_vld[k] !== 1'b1) begin bad++; $display("FAIL single_valid[%0d] got=%b exp=1", k, out_vld[k]); end
      if (out_dat[k] !== 32'hA5A5_0001) begin bad++; $display("FAIL single_data[%0d] got=%h exp=a5a50001", k, out_dat[k]); end
      if (out_ctl[k] !== 8'h03) begin bad++; $display("FAIL single_ctrl[%0d] got=%h exp=03", k, out_ctl[k]); end
      if (cnt[k] !== 4'd1) begin bad++; $display("FAIL single_count[%0d] got=%0d exp=1", k, cnt[k]); end
    end
    do_flush();
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 32'(i * 17);
      in_ctrl = 8'(8'h10 + i);
      tick();
    end
    in_valid = 1'b0;
    total += 4;
    if (cnt[0] !== 4'd2) begin bad++; $display("FAIL full_count got=%0d exp=2", cnt[0]); end
    if (in_rdy[0] !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b exp=0", in_rdy[0]); end
    if (cnt[1] !== 4'd3) begin bad++; $display("FAIL full3_count got=%0d exp=3", cnt[1]); end
    if (out_dat[0] !== 32'h11) begin bad++; $display("FAIL full_head got=%h exp=11", out_dat[0]); end
    out_ready = 1'b1;
    tick();
    total += 3;
    if (out_dat[0] !== 32'h22) begin bad++; $display("FAIL full_second got=%h exp=22", out_dat[0]); end
    if (in_rdy[0] !== 1'b1) begin bad++; $display("FAIL full_ready_after_pop got=%b exp=1", in_rdy[0]); end
    if (cnt[0] !== 4'd1) begin bad++; $display("FAIL full_count_after_pop got=%0d exp=1", cnt[0]); end
    tick();
    total += 2;
    if (out_vld[0] !== 1'b0) begin bad++; $display("FAIL full_drained got=%b exp=0", out_vld[0]); end
    if (out_dat[1] !== 32'h33) begin bad++; $display("FAIL full3_third got=%h exp=33", out_dat[1]); end
    out_ready = 1'b0;
    do_flush();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_data = 32'(i);
      in_ctrl = 8'(i);
      tick();
      for (int k = 0; k < 2; k++) begin
        total += 3;
        if (cnt[k] !== 4'd1) begin bad++; $display("FAIL stream_count[%0d] i=%0d got=%0d exp=1", k, i, cnt[k]); end
        if (out_dat[k] !== 32'(i)) begin bad++; $display("FAIL stream_data[%0d] got=%0d exp=%0d", k, out_dat[k], i); end
        if (out_ctl[k] !== 8'(i)) begin bad++; $display("FAIL stream_ctrl[%0d] got=%0d exp=%0d", k, out_ctl[k], i); end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    do_flush();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_ctrl = 8'hff;
    for (int i = 0; i < 2; i++) begin
      in_data = 32'(256 + i);
      tick();
    end
    flush = 1'b1;
    out_ready = 1'b1;
    in_data = 32'h102;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total += 3;
      if (cnt[k] !== 4'd0) begin bad++; $display("FAIL flush_count[%0d] got=%0d exp=0", k, cnt[k]); end
      if (out_vld[k] !== 1'b0) begin bad++; $display("FAIL flush_valid[%0d] got=%b exp=0", k, out_vld[k]); end
      if (out_ctl[k] !== 8'h0) begin bad++; $display("FAIL flush_ctrl[%0d] got=%h exp=0", k, out_ctl[k]); end
`ifdef PIPE_STAGE_BUF_ZERO_ON_FLUSH_EN
      total++;
      if (out_dat[k] !== 32'h0) begin bad++; $display("FAIL flush_data[%0d] got=%h exp=0", k, out_dat[k]); end
`endif
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (cnt[k] !== 4'd0) begin bad++; $display("FAIL flush_input_dropped[%0d] got=%0d exp=0", k, cnt[k]); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_depth1();
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_ctrl = 8'h40;
    for (int c = 0; c < 12; c++) begin
      in_data = 32'(c / 2 + 1);
      total++;
      if (in_rdy[2] !== (c % 2 == 0)) begin bad++; $display("FAIL depth1_ready c=%0d got=%b exp=%b", c, in_rdy[2], c % 2 == 0); end
      if (c % 2 == 1) begin
        total += 2;
        if (out_vld[2] !== 1'b1) begin bad++; $display("FAIL depth1_valid c=%0d got=%b exp=1", c, out_vld[2]); end
        if (out_dat[2] !== 32'((c + 1) / 2)) begin bad++; $display("FAIL depth1_data c=%0d got=%0d exp=%0d", c, out_dat[2], (c + 1) / 2); end
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    do_flush();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush = ($urandom % 20) == 0;
      in_data = $urandom;
      in_ctrl = 8'($urandom);
      for (int k = 0; k < 3; k++) begin
        logic [39:0] h;
        h = mlog[k][mrd[k]];
        total += 4;
        if (cnt[k] !== 4'(msz(k))) begin bad++; $display("FAIL rand_count[%0d] n=%0d got=%0d exp=%0d", k, n, cnt[k], msz(k)); end
        if (in_rdy[k] !== (msz(k) != dep(k))) begin bad++; $display("FAIL rand_in_ready[%0d] n=%0d got=%b", k, n, in_rdy[k]); end
        if (out_vld[k] !== (msz(k) != 0)) begin bad++; $display("FAIL rand_out_valid[%0d] n=%0d got=%b", k, n, out_vld[k]); end
        if (out_ctl[k] !== (msz(k) != 0 ? h[7:0] : 8'h0)) begin bad++; $display("FAIL rand_out_ctrl[%0d] n=%0d got=%h", k, n, out_ctl[k]); end
        if (msz(k) != 0) begin
          total++;
          if (out_dat[k] !== h[39:8]) begin bad++; $display("FAIL rand_out_data[%0d] n=%0d got=%h exp=%h", k, n, out_dat[k], h[39:8]); end
        end
      end
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_stream();
    test_flush();
    test_depth1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised elastic pipeline stage register, the successor to the fixed FD/DE/EW stage registers.
- Carries a generic data payload plus a control-bit bundle between two pipeline stages through a DEPTH-entry circular buffer.
- Uses a valid/ready handshake in place of stall inputs, plus a synchronous flush that kills every held entry.
- Control bits seen downstream are forced to zero whenever no valid entry is presented, so a bubble is always a NOP.

Parameters:
DATA_W, 32, width of payload (operands, PC, immediates).
CTRL_W, 8, width of control bundle (reg_write, mem_write, branch_en, ...); zeroed on bubble.
DEPTH, 2, number of buffer entries. Legal range 1..8.
CNT_W, 4, width of the occupancy counter. Must satisfy 2^CNT_W > DEPTH.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous active-high reset.
flush  in  1  synchronous kill of all held entries and of the current input.
in_valid  in  1  upstream has an entry.
in_ready  out  1  stage can accept an entry this cycle.
in_data  in  DATA_W  upstream payload.
in_ctrl  in  CTRL_W  upstream control bundle.
out_valid  out  1  head entry is valid.
out_ready  in  1  downstream consumes the head this cycle.
out_data  out  DATA_W  head payload.
out_ctrl  out  CTRL_W  head control bundle; all-zero when out_valid=0.
count  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high.
- Reset values: count=0, out_valid=0, out_data=0, out_ctrl=0, in_ready=1; read and write pointers=0; all storage cleared to 0.
- Storage: DEPTH entries of {DATA_W+CTRL_W} bits, with read and write pointers that wrap modulo DEPTH. Non-power-of-2 DEPTH wraps explicitly from DEPTH-1 to 0.
- in_ready = (count != DEPTH).
  - in_ready is derived from registered state only. There is no combinational path from out_ready to in_ready.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- Latency: an entry pushed at edge N is presented on out_* after edge N when the buffer was empty, i.e. one-cycle latency.
- FIFO order is always preserved.
- Presented outputs:
  - out_valid = (count != 0).
  - out_data = storage[rd_ptr].
  - out_ctrl = out_valid ? storage[rd_ptr].ctrl : 0.
- Occupancy update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance. This is legal when count is between 1 and DEPTH-1.
- Full (count=DEPTH): in_ready=0 and in_valid is ignored, even if out_ready=1 that cycle. in_ready rises the cycle after a pop.
- Empty (count=0): out_ready is ignored.
- Flush:
  - At the next edge: count=0, both pointers=0, out_valid=0.
  - A same-cycle push and pop are both suppressed.
  - flush has priority over every handshake.
  - out_ctrl is 0 from the cycle after flush.
- reset asserted mid-transfer: every state element returns to its reset value immediately, without waiting for a clock edge.
- With DEPTH=1: behaves as the legacy stage register with handshake. Push and pop in the same cycle are impossible because in_ready=0 while full.

Optional Feature:
PIPE_STAGE_BUF_ZERO_ON_FLUSH_EN
- Defined: flush also clears every storage entry to 0, so out_data reads 0 after a flush. Matches the legacy flush-to-zero behaviour.
- Undefined: flush clears only the pointers and count; storage keeps stale data.
  - out_data is don't-care while out_valid=0.
  - out_ctrl is still forced to 0.
  - This saves the clear logic on wide payloads.

Test Plan:
1. Reset then idle, DEPTH=2 -> count=0, in_ready=1, out_valid=0, out_data=0, out_ctrl=0. Pulse reset mid-cycle with 1 entry held -> out_valid=0 immediately, without a clock edge.
2. Push 0xA5A5_0001 (ctrl 0x03) with out_ready=0 -> next cycle out_valid=1, out_data=0xA5A5_0001, out_ctrl=0x03, count=1.
3. Push 0x11, 0x22, 0x33 back-to-back with out_ready=0 -> count=2, in_ready=0, 0x33 not accepted. Raise out_ready -> 0x11 then 0x22 presented in order, in_ready=1 after the first pop.
4. Streaming, with in_valid=1 and out_ready=1 every cycle for 10 cycles, values 1..10 -> count stays 1 and out_data sequence is 1..10 with no gaps. Repeat with DEPTH=3 to check pointer wrap.
5. Flush with count=2 and in_valid=1 -> next cycle count=0, out_valid=0, out_ctrl=0, input not stored. With PIPE_STAGE_BUF_ZERO_ON_FLUSH_EN defined, out_data=0.
6. DEPTH=1, in_valid=1 and out_ready=1 every cycle -> alternates accept/present, giving a throughput of one entry every 2 cycles, with order preserved.
